// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, NOP encoding,
// default widths and the fetch state enum.
package pipeline_pkg;

  localparam int PC_W_DEF    = 48;
  localparam int INSTR_W_DEF = 48;

  localparam logic [5:0] OP_J   = 6'h20;
  localparam logic [5:0] OP_NOP = 6'h21;
  localparam logic [5:0] OP_BNE = 6'h22;
  localparam logic [5:0] OP_BEQ = 6'h23;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR =
    {OP_NOP, {(INSTR_W_DEF-6){1'b0}}};

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding {instruction, pc1}.
// Reset and flush both empty it in one edge.
module fetch_fifo #(
  parameter int W     = 96,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  // Storage write; contents are don't-care once pointers reset.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, in-order imem requests, prefetch FIFO
// and the IF/ID output register with stall/redirect handling.
module instr_fetch_unit
  import pipeline_pkg::*;
#(
  parameter int              PC_W       = 48,
  parameter int              INSTR_W    = 48,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc1,
  output logic               instr_valid
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam int UW = CW + 1;
  localparam logic [INSTR_W-1:0] NOP =
    {OP_NOP, {(INSTR_W-6){1'b0}}};

  fetch_state_t        state_q;
  fetch_state_t        state_d;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     resp_pc_q;
  logic [CW-1:0]       out_q;
  logic [CW-1:0]       out_d;
  logic                req_en_q;

  logic                xfer;
  logic                rsp;
  logic                push;
  logic                pop;
  logic [UW-1:0]       used;
  logic                credit_ok;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [INSTR_W+PC_W-1:0] fifo_head;
  logic [INSTR_W-1:0]  head_instr;
  logic [PC_W-1:0]     head_pc1;
  logic                unused_full;

  assign unused_full = fifo_full;

  assign {head_instr, head_pc1} = fifo_head;

  // A pop this cycle frees a slot, keeping 1 instr/cycle at depth 2.
  assign pop = !stall && !fifo_empty && !redirect_valid;
  assign used = UW'(out_q) + UW'(fifo_count) - UW'(pop);
  assign credit_ok = (used < UW'(FIFO_DEPTH));

  assign imem_req = req_en_q && (state_q == FETCH)
                 && !redirect_valid && credit_ok;
  assign imem_addr = pc_q;

  assign xfer = imem_req && imem_ready;
  assign rsp  = imem_rvalid && (out_q != '0);
  assign push = rsp && (state_q == FETCH) && !redirect_valid;
  assign out_d = out_q + CW'(xfer) - CW'(rsp);

  fetch_fifo #(
    .W     (INSTR_W + PC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, resp_pc_q + PC_W'(1)}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next state: redirect wins; FLUSH drains until nothing is in flight.
  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = (out_d != '0) ? FLUSH : FETCH;
    else if (state_q == FLUSH && out_d == '0)
      state_d = FETCH;
  end

  // PC, response address tracker and in-flight counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      req_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      req_en_q <= 1'b1;
      if (redirect_valid) begin
        pc_q      <= redirect_pc;
        resp_pc_q <= redirect_pc;
      end else begin
        if (xfer) pc_q      <= pc_q + PC_W'(1);
        if (push) resp_pc_q <= resp_pc_q + PC_W'(1);
      end
    end
  end

  // IF/ID output register: redirect bubbles, stall holds, else pop or NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP;
      pc1         <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      instruction <= NOP;
      instr_valid <= 1'b0;
    end else if (!stall) begin
      if (!fifo_empty) begin
        instruction <= head_instr;
        pc1         <= head_pc1;
        instr_valid <= 1'b1;
      end else begin
        instruction <= NOP;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: table-driven stream
// plus hand sequences for redirect, ready-low, reset and wrap.
module tb_instr_fetch_unit;
  import pipeline_pkg::*;

  localparam logic [47:0] NOP = {6'h21, 42'h0};
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [47:0] redirect_pc;
  logic        imem_req;
  logic [47:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [47:0] imem_rdata;
  logic [47:0] instruction;
  logic [47:0] pc1;
  logic        instr_valid;

  logic        rst2;
  logic        zero_s;
  logic [47:0] zero_pc;
  logic        one_r;
  logic        req2;
  logic [47:0] addr2;
  logic        rvalid2;
  logic [47:0] rdata2;
  logic [47:0] instr2;
  logic [47:0] pc1_2;
  logic        valid2;

  int checks = 0;
  int failures = 0;

  int          lat;
  logic        force_rv;
  logic        pv0, pv1, pv2;
  logic [47:0] pa0, pa1, pa2, ra;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instruction(instruction),
    .pc1(pc1), .instr_valid(instr_valid)
  );

  instr_fetch_unit #(.RESET_PC(ONES)) dut2 (
    .clk(clk), .rst(rst2), .stall(zero_s),
    .redirect_valid(zero_s), .redirect_pc(zero_pc),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ready(one_r), .imem_rvalid(rvalid2),
    .imem_rdata(rdata2), .instruction(instr2),
    .pc1(pc1_2), .instr_valid(valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    pv0 = 0; pv1 = 0; pv2 = 0;
    pa0 = '0; pa1 = '0; pa2 = '0;
  end

  always @(posedge clk) begin
    pv0 <= imem_req && imem_ready;
    pa0 <= imem_addr;
    pv1 <= pv0;
    pa1 <= pa0;
    pv2 <= req2;
    pa2 <= addr2;
  end

  assign ra = (lat == 1) ? pa0 : pa1;
  assign imem_rvalid = force_rv | ((lat == 1) ? pv0 : pv1);
  assign imem_rdata = force_rv ? 48'h0000_DEAD_BEEF
                               : {6'hB, ra[41:0]};
  assign rvalid2 = pv2;
  assign rdata2 = {6'hB, pa2[41:0]};

  function automatic logic [47:0] ins(input logic [47:0] a);
    return {6'hB, a[41:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input bit v,
                           input logic [47:0] p1);
    logic [47:0] a;
    a = p1 - 48'd1;
    chk({nm, ".valid"}, 64'(instr_valid), 64'(v));
    chk({nm, ".pc1"}, 64'(pc1), 64'(p1));
    chk({nm, ".instr"}, 64'(instruction),
        v ? 64'(ins(a)) : 64'(NOP));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          stall;
    bit          chk_req;
    bit          exp_req;
    bit          exp_v;
    logic [47:0] exp_pc1;
  } vec_t;

  vec_t tbl [16];

  initial begin
    int n;
    bit seen;

    rst = 1; stall = 0; redirect_valid = 0;
    redirect_pc = '0; imem_ready = 1; force_rv = 0;
    lat = 1; rst2 = 1; zero_s = 0; zero_pc = '0; one_r = 1;

    tbl[0]  = '{0, 1, 0, 0, 48'd0};
    tbl[1]  = '{0, 1, 1, 0, 48'd0};
    tbl[2]  = '{0, 0, 0, 0, 48'd0};
    tbl[3]  = '{0, 0, 0, 1, 48'd1};
    tbl[4]  = '{0, 0, 0, 1, 48'd2};
    tbl[5]  = '{0, 0, 0, 1, 48'd3};
    tbl[6]  = '{0, 0, 0, 1, 48'd4};
    tbl[7]  = '{0, 0, 0, 1, 48'd5};
    tbl[8]  = '{1, 1, 0, 1, 48'd5};
    tbl[9]  = '{1, 1, 0, 1, 48'd5};
    tbl[10] = '{1, 1, 0, 1, 48'd5};
    tbl[11] = '{0, 1, 1, 1, 48'd6};
    tbl[12] = '{0, 0, 0, 1, 48'd7};
    tbl[13] = '{0, 0, 0, 1, 48'd8};
    tbl[14] = '{0, 0, 0, 1, 48'd9};
    tbl[15] = '{0, 0, 0, 1, 48'd10};

    repeat (3) tick;
    check_out("reset", 0, 48'd0);
    chk("reset.req", 64'(imem_req), 64'd0);
    chk("reset.addr", 64'(imem_addr), 64'd0);
    rst = 0;

    for (int i = 0; i < 16; i++) begin
      stall = tbl[i].stall;
      #1;
      if (tbl[i].chk_req)
        chk($sformatf("tbl%0d.req", i), 64'(imem_req),
            64'(tbl[i].exp_req));
      tick;
      check_out($sformatf("tbl%0d", i), tbl[i].exp_v,
                tbl[i].exp_pc1);
    end

    stall = 1; redirect_valid = 1; redirect_pc = 48'h200;
    #1;
    chk("redir.req", 64'(imem_req), 64'd0);
    tick;
    check_out("redir_stall", 0, 48'd10);
    redirect_valid = 0; stall = 0;
    #1;
    chk("redir.req1", 64'(imem_req), 64'd1);
    chk("redir.addr", 64'(imem_addr), 64'h200);
    tick;
    check_out("redir_r1", 0, 48'd10);
    tick;
    check_out("redir_r2", 0, 48'd10);
    tick;
    check_out("redir_r3", 1, 48'h201);
    tick;
    check_out("redir_r4", 1, 48'h202);
    tick;
    check_out("redir_r5", 1, 48'h203);

    imem_ready = 0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk($sformatf("rdy%0d.req", j), 64'(imem_req), 64'd1);
      chk($sformatf("rdy%0d.addr", j), 64'(imem_addr), 64'h205);
      tick;
      if (j == 0)
        check_out("rdy0", 1, 48'h204);
      else if (j == 1)
        check_out("rdy1", 1, 48'h205);
      else
        check_out($sformatf("rdy%0d", j), 0, 48'h205);
    end
    imem_ready = 1;
    tick;
    check_out("rdy_back1", 0, 48'h205);
    tick;
    check_out("rdy_back2", 0, 48'h205);
    tick;
    check_out("rdy_back3", 1, 48'h206);

    stall = 1;
    tick;
    tick;
    check_out("fill", 1, 48'h206);
    stall = 0; rst = 1;
    tick;
    check_out("rst_full", 0, 48'd0);
    chk("rst_full.req", 64'(imem_req), 64'd0);
    chk("rst_full.addr", 64'(imem_addr), 64'd0);
    rst = 0; force_rv = 1;
    tick;
    force_rv = 0;
    check_out("stale1", 0, 48'd0);
    tick;
    check_out("stale2", 0, 48'd0);
    tick;
    check_out("stale3", 0, 48'd0);
    tick;
    check_out("stale4", 1, 48'd1);
    tick;
    check_out("stale5", 1, 48'd2);

    rst = 1; lat = 2;
    repeat (3) tick;
    rst = 0;
    tick;
    tick;
    tick;
    check_out("l2_e3", 0, 48'd0);
    redirect_valid = 1; redirect_pc = 48'h100;
    #1;
    chk("l2.redir_req", 64'(imem_req), 64'd0);
    tick;
    check_out("l2_e4", 0, 48'd0);
    redirect_valid = 0;
    #1;
    chk("l2.flush_req", 64'(imem_req), 64'd0);
    tick;
    check_out("l2_e5", 0, 48'd0);
    chk("l2.req", 64'(imem_req), 64'd1);
    chk("l2.addr", 64'(imem_addr), 64'h100);
    n = 5;
    seen = 0;
    while (!seen && n < 20) begin
      tick;
      n++;
      if (instr_valid) seen = 1;
    end
    chk("l2.first_edge", 64'(n), 64'd9);
    check_out("l2_first", 1, 48'h101);

    repeat (2) tick;
    chk("wrap.rst_req", 64'(req2), 64'd0);
    chk("wrap.rst_addr", 64'(addr2), 64'(ONES));
    rst2 = 0;
    tick;
    chk("wrap.req", 64'(req2), 64'd1);
    chk("wrap.addr", 64'(addr2), 64'(ONES));
    tick;
    chk("wrap.addr0", 64'(addr2), 64'd0);
    tick;
    chk("wrap.e3_valid", 64'(valid2), 64'd0);
    tick;
    chk("wrap.valid", 64'(valid2), 64'd1);
    chk("wrap.pc1", 64'(pc1_2), 64'd0);
    chk("wrap.instr", 64'(instr2), 64'(ins(ONES)));
    tick;
    chk("wrap.pc1b", 64'(pc1_2), 64'd1);
    chk("wrap.instrb", 64'(instr2), 64'(ins(48'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage feeding the IF/ID pipeline register. Holds the program counter, issues in-order word reads to instruction memory through a request/response handshake, buffers returned words in a small prefetch FIFO, and presents one 48-bit instruction plus its PC+1 per cycle downstream. Handles downstream stall and branch/jump redirect with flush, inserting NOP bubbles when no instruction is available.

## Interface
Parameters:
- PC_W, 48, PC and instruction-memory address width (word addressed)
- INSTR_W, 48, instruction width
- RESET_PC, 48'h0, PC value after reset
- FIFO_DEPTH, 2, prefetch entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream cannot accept; hold outputs
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  PC_W  new fetch target
- imem_req  out  1  read request valid
- imem_addr  out  PC_W  read word address
- imem_ready  in  1  memory accepts request (transfer = imem_req && imem_ready)
- imem_rvalid  in  1  read data valid, in request order, latency ≥1 cycle
- imem_rdata  in  INSTR_W  read data
- instruction  out  INSTR_W  instruction to IF/ID
- pc1  out  PC_W  address of instruction + 1
- instr_valid  out  1  instruction is real (0 = NOP bubble)

## Operation
- States: FETCH, FLUSH. Reset → FETCH, pc = RESET_PC, FIFO empty, outstanding = 0.
- FETCH: imem_req = 1 when outstanding + fifo_count < FIFO_DEPTH; imem_addr = pc. On transfer: pc += 1 (wraps modulo 2^PC_W), outstanding += 1.
- Response: imem_rvalid in FETCH pushes {imem_rdata, addr+1} into FIFO, outstanding −= 1. Addr tracked by an in-order address queue or equivalent. Credit rule guarantees no overflow; rvalid with outstanding = 0 is ignored.
- Output register: if !stall, load FIFO head (pop, instr_valid = 1) or, if empty, NOP = {6'h21, 42'h0}, pc1 held, instr_valid = 0. If stall, hold all three outputs, no pop.
- Redirect (highest priority): flush FIFO, pc = redirect_pc, output register forced to NOP/instr_valid = 0 even if stall, no request issued that cycle. If outstanding (after this cycle's rvalid) > 0 → FLUSH, else stay FETCH.
- FLUSH: imem_req = 0; each rvalid discarded, outstanding −= 1; at outstanding reaching 0 → FETCH next cycle. Redirect in FLUSH overwrites pc, stays FLUSH.
- Simultaneous push and pop in one cycle permitted; count unchanged.

## Timing
- Reset values: instruction = NOP, pc1 = 0, instr_valid = 0, imem_req = 0, imem_addr = RESET_PC.
- imem_req/imem_addr are functions of registered state only (no combinational path from imem_ready or rvalid).
- rvalid sampled at edge E → FIFO entry after E → on output after E+1 (min 2 edges rvalid-to-output, no bypass).
- First request cycle after reset: cycle 1 after rst deasserts. With 1-cycle memory, first valid instruction after edge 4 from rst deassertion; steady state 1 instruction/cycle at FIFO_DEPTH = 2.
- Redirect at edge R: bubble visible after R; first request to redirect_pc at cycle after R (FETCH) or cycle after last discarded response (FLUSH).
- rst mid-operation: all state to reset values in one edge; in-flight responses after reset are ignored (outstanding = 0).

## Structure
- Shared package (pipeline_pkg): NOP opcode 6'h21, NOP_INSTR constant, opcode constants (J 6'h20, BNE 6'h22, BEQ 6'h23), PC_W/INSTR_W defaults, state enum.
- Sub-module fetch_fifo: parameterised sync FIFO (push, pop, flush, count, full, empty), reset/flush to empty; holds {instruction, pc1}.

## Test plan
- Reset then 1-cycle memory returning rdata = {6'hB, addr[41:0]}: outputs addr 0,1,2,… with pc1 = 1,2,3 at one per cycle, instr_valid = 1, no gaps after fill.
- stall held 3 cycles mid-stream: outputs frozen, imem_req drops once FIFO+outstanding = 2, no instruction lost or duplicated after release.
- redirect_valid with redirect_pc = 48'h100 while 2 outstanding: both responses discarded, NOP bubble output, next request addr 48'h100, next valid pc1 = 48'h101.
- imem_ready low 5 cycles: imem_req stays 1 with stable imem_addr, outputs NOP/instr_valid = 0 once FIFO empties.
- RESET_PC = 48'hFFFF_FFFF_FFFF: addresses wrap to 0, pc1 of first instruction = 0.
- rst asserted with FIFO full: next cycle instruction = NOP, instr_valid = 0, imem_addr = RESET_PC, stale rvalid ignored.
